// File: rtl/sm83_irq_ctl.sv
// Interrupt controller and bus responder for the sm83 core: latches request edges
// into IF, holds IE, serves IF/IE over p_rd/p_wr, and drives irq / consumes iack.
module sm83_irq_ctl #(
  parameter int unsigned          WORD_SIZE = 8,
  parameter int unsigned          ADR_WIDTH = 16,
  parameter int unsigned          NUM_IRQS  = 5,
  parameter logic [ADR_WIDTH-1:0] IF_ADR    = 16'hff0f,
  parameter logic [ADR_WIDTH-1:0] IE_ADR    = 16'hffff
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 dout_oe,
  input  logic                 p_rd,
  input  logic                 p_wr,
  input  logic [NUM_IRQS-1:0]  req,
  output logic [WORD_SIZE-1:0] irq,
  input  logic [WORD_SIZE-1:0] iack
);

  typedef enum logic {W_IDLE, W_ACTIVE} wr_state_e;
  typedef enum logic [1:0] {T_NONE, T_IF, T_IE} wr_tgt_e;

  wr_state_e            wr_state_q, wr_state_d;
  wr_tgt_e              tgt_q, tgt_d, adr_tgt;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [NUM_IRQS-1:0]  req_q, req_edge;
  logic                 p_wr_q, p_rd_q;
  logic [NUM_IRQS-1:0]  if_q, if_d, if_t;
  logic [WORD_SIZE-1:0] ie_q, ie_d;
  logic [WORD_SIZE-1:0] irq_q, irq_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 dout_oe_q, dout_oe_d;
  logic [WORD_SIZE-1:0] rd_if_val, rd_val;
  logic                 rd_rise;
  logic                 wr_commit_if, wr_commit_ie;

  always_comb begin
    adr_tgt = T_NONE;
    if (adr == IF_ADR)      adr_tgt = T_IF;
    else if (adr == IE_ADR) adr_tgt = T_IE;
  end

  // Write handshake FSM: a strobe must rise while idle, so one held across reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset) wr_state_q <= W_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE:   if (p_wr && !p_wr_q) wr_state_d = W_ACTIVE;
      W_ACTIVE: if (!p_wr)           wr_state_d = W_IDLE;
      default:                       wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_commit_if = (wr_state_q == W_ACTIVE) && !p_wr && (tgt_q == T_IF);
    wr_commit_ie = (wr_state_q == W_ACTIVE) && !p_wr && (tgt_q == T_IE);
  end

  always_comb begin
    tgt_d   = tgt_q;
    wdata_d = wdata_q;
    if (wr_state_q == W_IDLE && p_wr && !p_wr_q) begin
      tgt_d   = adr_tgt;
      wdata_d = din;
    end else if (wr_state_q == W_ACTIVE && p_wr && adr_tgt != T_NONE) begin
      tgt_d   = adr_tgt;
      wdata_d = din;
    end
  end

  // IF update order: CPU write, then iack clear, then new edges on top.
  always_comb begin
    req_edge = req & ~req_q;
    if_t     = wr_commit_if ? wdata_q[NUM_IRQS-1:0] : if_q;
    if_t     = if_t & ~iack[NUM_IRQS-1:0];
    if_d     = if_t | req_edge;
    ie_d     = wr_commit_ie ? wdata_q : ie_q;
    irq_d    = '0;
    irq_d[NUM_IRQS-1:0] = if_q & ie_q[NUM_IRQS-1:0];
  end

  always_comb begin
    rd_if_val                = '1;
    rd_if_val[NUM_IRQS-1:0]  = if_q;
    rd_val                   = (adr_tgt == T_IF) ? rd_if_val : ie_q;
    rd_rise                  = p_rd && !p_rd_q && !p_wr && (adr_tgt != T_NONE);
    dout_d                   = rd_rise ? rd_val : dout_q;
    dout_oe_d                = rd_rise || (dout_oe_q && p_rd && !p_wr);
  end

  always_ff @(posedge clk) begin
    req_q  <= req;
    p_wr_q <= p_wr;
    p_rd_q <= p_rd;
    if (!reset) begin
      tgt_q     <= T_NONE;
      wdata_q   <= '0;
      if_q      <= '0;
      ie_q      <= '0;
      irq_q     <= '0;
      dout_q    <= '0;
      dout_oe_q <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      wdata_q   <= wdata_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
    end
  end

  generate
    if (NUM_IRQS < WORD_SIZE) begin : g_iack_hi
      logic unused_iack_hi;
      assign unused_iack_hi = ^iack[WORD_SIZE-1:NUM_IRQS];
    end
  endgenerate

  assign irq     = irq_q;
  assign dout    = dout_q;
  assign dout_oe = dout_oe_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed scoreboard bench for sm83_irq_ctl.
module tb_sm83_irq_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        p_rd;
  logic        p_wr;
  logic [4:0]  req;
  logic [7:0]  irq;
  logic [7:0]  iack;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];

  sm83_irq_ctl #(
    .WORD_SIZE(8),
    .ADR_WIDTH(16),
    .NUM_IRQS (5),
    .IF_ADR   (16'hff0f),
    .IE_ADR   (16'hffff)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .adr    (adr),
    .din    (din),
    .dout   (dout),
    .dout_oe(dout_oe),
    .p_rd   (p_rd),
    .p_wr   (p_wr),
    .req    (req),
    .irq    (irq),
    .iack   (iack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] e);
    sb_t t;
    t.tag = tag;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic check(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int n);
    adr  = a;
    din  = d;
    p_wr = 1'b1;
    repeat (n) tick();
    p_wr = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    adr  = a;
    p_rd = 1'b1;
    push({tag, "_oe_first"}, 16'h0);
    check(dout_oe);
    tick();
    push({tag, "_data"}, exp);
    push({tag, "_oe"}, 16'h1);
    check(dout);
    check(dout_oe);
    p_rd = 1'b0;
    tick();
    push({tag, "_oe_drop"}, 16'h0);
    check(dout_oe);
  endtask

  initial begin
    reset = 1'b0; adr = '0; din = '0; p_rd = 1'b0; p_wr = 1'b0;
    req = 5'b00001; iack = '0;

    // 1: reset with a held request level
    tick(); tick();
    push("rst_oe", 16'h0);   check(dout_oe);
    push("rst_dout", 16'h0); check(dout);
    push("rst_irq", 16'h0);  check(irq);
    reset = 1'b1;
    tick();
    push("post_rst_if", 16'h0);  check(dut.if_q);
    push("post_rst_irq", 16'h0); check(irq);
    tick();
    push("post_rst_irq2", 16'h0); check(irq);
    push("post_rst_oe", 16'h0);   check(dout_oe);

    // 2: enable all, edge on req[2]
    wr(16'hffff, 8'h1f, 3);
    req = 5'b00101;
    tick();
    push("edge_if", 16'h04);  check(dut.if_q);
    push("edge_irq0", 16'h0); check(irq);
    req = 5'b00001;
    tick();
    push("edge_irq", 16'h04); check(irq);

    // 3: iack clear, then iack racing a new edge
    iack = 8'h04;
    tick();
    push("iack_if", 16'h0);   check(dut.if_q);
    push("iack_irq0", 16'h04); check(irq);
    iack = 8'h00;
    tick();
    push("iack_irq", 16'h0);  check(irq);
    req = 5'b00101;
    tick();
    req = 5'b00001;
    tick();
    req = 5'b00101; iack = 8'h04;
    tick();
    push("iack_vs_edge_if", 16'h04); check(dut.if_q);
    req = 5'b00001; iack = 8'h00;
    tick();
    push("iack_vs_edge_irq", 16'h04); check(irq);
    iack = 8'h04;
    tick();
    iack = 8'h00;

    // 4: CPU write of IF, reads of IF and IE
    wr(16'hff0f, 8'hff, 2);
    push("wr_if", 16'h1f); check(dut.if_q);
    tick();
    push("wr_if_irq", 16'h1f); check(irq);
    rd(16'hff0f, 8'hff, "rd_if_ff");
    wr(16'hffff, 8'he1, 2);
    rd(16'hffff, 8'he1, "rd_ie_e1");

    // 5: snapshot stays stable across a mid-read edge
    req = 5'b00000;
    tick();
    wr(16'hff0f, 8'h00, 1);
    push("clr_if", 16'h0); check(dut.if_q);
    adr = 16'hff0f; p_rd = 1'b1;
    tick();
    req = 5'b00001;
    push("snap_d0", 16'he0); check(dout);
    tick();
    push("snap_d1", 16'he0); check(dout);
    push("snap_oe1", 16'h1); check(dout_oe);
    tick();
    push("snap_d2", 16'he0); check(dout);
    p_rd = 1'b0;
    tick();
    push("snap_oe_drop", 16'h0); check(dout_oe);
    push("snap_hold", 16'he0);   check(dout);
    rd(16'hff0f, 8'he1, "rd_if_e1");

    // 6: edge beats a CPU write at the commit cycle; non-matching write ignored
    adr = 16'hff0f; din = 8'h00; p_wr = 1'b1;
    tick();
    p_wr = 1'b0; req = 5'b10001;
    tick();
    push("edge_vs_wr_if", 16'h10); check(dut.if_q);
    wr(16'hc000, 8'h55, 2);
    push("nomatch_if", 16'h10); check(dut.if_q);
    rd(16'hffff, 8'he1, "nomatch_ie");

    // Address moving off target mid-strobe keeps the earlier captured match
    adr = 16'hffff; din = 8'h0f; p_wr = 1'b1;
    tick();
    adr = 16'hc000; din = 8'haa;
    tick();
    p_wr = 1'b0;
    tick();
    rd(16'hffff, 8'h0f, "midstrobe_ie");

    // Upper iack bits ignored, multi-hot clears bit 4
    iack = 8'hf0;
    tick();
    iack = 8'h00;
    push("iack_multi_if", 16'h0); check(dut.if_q);

    // Simultaneous strobes: write path wins, no read drive
    adr = 16'hff0f; p_rd = 1'b1; p_wr = 1'b1;
    tick();
    tick();
    push("both_oe", 16'h0); check(dout_oe);
    p_rd = 1'b0; p_wr = 1'b0; din = 8'h00;
    tick();

    // Reset mid read strobe: held strobe must not produce a read
    adr = 16'hffff; p_rd = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    push("rst_mid_rd_oe", 16'h0); check(dout_oe);
    p_rd = 1'b0;
    tick();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover count=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm83_irq_ctl.md
Name: sm83_irq_ctl

Overview:
Interrupt controller and bus responder on the far side of the sm83 core's memory and interrupt interface.
- Latches peripheral interrupt request edges into IF.
- Holds the IE enable mask.
- Exposes IF and IE as CPU-addressable registers via the core's p_rd/p_wr strobes.
- Drives the core's irq vector and clears pending bits on the core's iack.

Parameters:
WORD_SIZE, 8, data bus width; also width of irq/iack vectors
ADR_WIDTH, 16, address bus width
NUM_IRQS, 5, number of implemented interrupt sources (bits 0..NUM_IRQS-1; must be <= WORD_SIZE)
IF_ADR, 16'hff0f, address of the interrupt flag register
IE_ADR, 16'hffff, address of the interrupt enable register

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous reset, active-low (0 = reset)
adr  input  ADR_WIDTH  CPU address bus
din  input  WORD_SIZE  CPU write data (core dout)
dout  output  WORD_SIZE  read data to CPU (core din)
dout_oe  output  1  read data valid / drive enable
p_rd  input  1  CPU read strobe, active-high
p_wr  input  1  CPU write strobe, active-high
req  input  NUM_IRQS  peripheral interrupt request levels; rising edge = event
irq  output  WORD_SIZE  pending-and-enabled vector to core
iack  input  WORD_SIZE  interrupt acknowledge from core, at most one bit set

Behaviour:
- Reset (reset==0 at posedge):
  - IF=0, IE=0, irq=0, dout=0, dout_oe=0; pending write discarded.
  - req_q loads req, so a level held across reset release produces no event.
- Edge detect: edge = req & ~req_q; req_q <= req every cycle.
- IF register (NUM_IRQS bits), next-state order per cycle:
  - t = wr_commit_if ? wdata[NUM_IRQS-1:0] : IF
  - t &= ~iack[NUM_IRQS-1:0]
  - IF <= t | edge
  - Consequences: a new edge always wins over iack clear and over a CPU write; iack clear wins over a CPU write setting that bit.
- IE register (full WORD_SIZE bits, all stored and readable). Written only on wr_commit_ie.
- irq (registered, 1-cycle latency from IF/IE state):
  - irq[i] <= IF[i] & IE[i] for i < NUM_IRQS
  - irq[WORD_SIZE-1:NUM_IRQS] always 0
- Write handshake, two states (W_IDLE, W_ACTIVE), tracked via p_wr_q:
  - While p_wr==1 and adr matches IF_ADR or IE_ADR: capture wdata<=din and target<=match each cycle (last value wins).
  - Commit on the cycle p_wr_q==1 && p_wr==0 (strobe end), using captured wdata/target. That cycle asserts wr_commit_if or wr_commit_ie accordingly.
  - Strobe with no address match: no commit.
  - Address changing mid-strobe: the last matching address wins; if the final cycle does not match, the earlier captured match still commits.
- Read handshake:
  - On the cycle p_rd rises (p_rd && !p_rd_q) with an address hit, snapshot <= read value:
    - IF_ADR: {ones(WORD_SIZE-NUM_IRQS), IF}
    - IE_ADR: IE
  - From the next cycle while p_rd stays 1: dout_oe=1, dout=snapshot. The snapshot is stable even if IF changes mid-read.
  - dout_oe drops the cycle after p_rd falls. dout holds its last value when not driven.
  - Non-matching address: dout_oe stays 0.
- p_rd and p_wr are never both 1; if they are, the write path takes precedence and dout_oe=0.
- Reset mid-strobe: the strobe is abandoned; a new rising edge is required after reset release.
- iack bits at or above NUM_IRQS are ignored. Multiple-hot iack clears every indicated bit (no error).

Test Plan:
1. Reset held 2 cycles with req=5'b00001 then released, req held -> IF=0, irq=0 (no spurious edge); dout_oe=0 throughout.
2. Write IE=8'h1f (p_wr 3 cycles, adr=ffff); pulse req[2] -> IF=5'b00100 one cycle after the edge; irq=8'h04 one cycle later.
3. With IF=5'b00100, IE=1f, assert iack=8'h04 one cycle -> IF=0 next cycle, irq=0 the cycle after. Repeat with req[2] edge in the same cycle as iack -> IF[2] stays 1.
4. Write IF=8'hff via adr=ff0f -> IF=5'b11111. Read ff0f -> dout=8'hff with dout_oe from the 2nd p_rd cycle. Read ffff after writing IE=8'he1 -> dout=8'he1.
5. Read ff0f starting with IF=0; req[0] edge during the strobe -> dout stays 8'he0 for the whole strobe; next read returns 8'he1.
6. CPU write IF=0 coinciding with req[4] edge at the commit cycle -> IF=5'b10000. Write strobe to adr=c000 -> IF and IE unchanged.
